// File: rtl/score_controller.sv
// Pong score sequencer: tracks both players' points, runs the PAUSE/PLAY/OVER
// flow, and drives frame-synchronous 7-segment score digits.
module score_controller #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frame_start,
  input  logic       i_point_p1,
  input  logic       i_point_p2,
  input  logic       i_new_game,
  output logic [6:0] o_digit_p1,
  output logic [6:0] o_digit_p2,
  output logic       o_ball_freeze,
  output logic       o_serve,
  output logic       o_serve_dir,
  output logic       o_game_over,
  output logic       o_winner
);

  localparam logic [3:0] WIN_PTS  = 4'(WIN_SCORE);
  localparam logic [7:0] PAUSE_LD = 8'(PAUSE_FRAMES);
  localparam logic [7:0] BLINK_LD = 8'(BLINK_FRAMES);
  localparam logic [6:0] SEG_ZERO = 7'h77;

  typedef enum logic [1:0] {PLAY, PAUSE, OVER} state_t;

  state_t     state, state_nxt;
  logic [7:0] pause_cnt, pause_cnt_nxt;
  logic [7:0] blink_cnt, blink_cnt_nxt;
  logic       blink_vis, blink_vis_nxt;
  logic [3:0] score_p1, score_p1_nxt;
  logic [3:0] score_p2, score_p2_nxt;
  logic       serve_dir_nxt;
  logic       winner_nxt;
  logic       serve_nxt;
  logic [3:0] inc_p1, inc_p2;
  logic       hide_p1, hide_p2;

  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    case (value)
      4'd0:    seg_encode = 7'h77;
      4'd1:    seg_encode = 7'h24;
      4'd2:    seg_encode = 7'h5D;
      4'd3:    seg_encode = 7'h6D;
      4'd4:    seg_encode = 7'h2E;
      4'd5:    seg_encode = 7'h6B;
      4'd6:    seg_encode = 7'h7B;
      4'd7:    seg_encode = 7'h25;
      4'd8:    seg_encode = 7'h7F;
      4'd9:    seg_encode = 7'h6F;
      default: seg_encode = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] digit_view(input logic [3:0] value, input logic hide);
    digit_view = hide ? 7'h00 : seg_encode(value);
  endfunction

  assign inc_p1  = score_p1 + 4'd1;
  assign inc_p2  = score_p2 + 4'd1;
  // Only the winner's digit blinks; the loser keeps showing its score.
  assign hide_p1 = (state == OVER) && !blink_vis && !o_winner;
  assign hide_p2 = (state == OVER) && !blink_vis &&  o_winner;

  always_comb begin
    state_nxt     = state;
    pause_cnt_nxt = pause_cnt;
    blink_cnt_nxt = blink_cnt;
    blink_vis_nxt = blink_vis;
    score_p1_nxt  = score_p1;
    score_p2_nxt  = score_p2;
    serve_dir_nxt = o_serve_dir;
    winner_nxt    = o_winner;
    serve_nxt     = 1'b0;

    if (i_new_game) begin
      score_p1_nxt  = 4'd0;
      score_p2_nxt  = 4'd0;
      serve_dir_nxt = 1'b1;
      state_nxt     = PAUSE;
      pause_cnt_nxt = PAUSE_LD;
    end else begin
      case (state)
        PAUSE: begin
          if (i_frame_start) begin
            pause_cnt_nxt = pause_cnt - 8'd1;
            if (pause_cnt == 8'd1) begin
              serve_nxt = 1'b1;
              state_nxt = PLAY;
            end
          end
        end
        PLAY: begin
          // Player 1 wins a same-cycle tie; the player 2 pulse is dropped.
          if (i_point_p1) begin
            score_p1_nxt  = inc_p1;
            serve_dir_nxt = 1'b1;
            if (inc_p1 == WIN_PTS) begin
              state_nxt     = OVER;
              winner_nxt    = 1'b0;
              blink_vis_nxt = 1'b1;
              blink_cnt_nxt = BLINK_LD;
            end else begin
              state_nxt     = PAUSE;
              pause_cnt_nxt = PAUSE_LD;
            end
          end else if (i_point_p2) begin
            score_p2_nxt  = inc_p2;
            serve_dir_nxt = 1'b0;
            if (inc_p2 == WIN_PTS) begin
              state_nxt     = OVER;
              winner_nxt    = 1'b1;
              blink_vis_nxt = 1'b1;
              blink_cnt_nxt = BLINK_LD;
            end else begin
              state_nxt     = PAUSE;
              pause_cnt_nxt = PAUSE_LD;
            end
          end
        end
        OVER: begin
          if (i_frame_start) begin
            if (blink_cnt == 8'd1) begin
              blink_vis_nxt = !blink_vis;
              blink_cnt_nxt = BLINK_LD;
            end else begin
              blink_cnt_nxt = blink_cnt - 8'd1;
            end
          end
        end
        default: state_nxt = PAUSE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= PAUSE;
      pause_cnt     <= PAUSE_LD;
      blink_cnt     <= BLINK_LD;
      blink_vis     <= 1'b1;
      score_p1      <= 4'd0;
      score_p2      <= 4'd0;
      o_digit_p1    <= SEG_ZERO;
      o_digit_p2    <= SEG_ZERO;
      o_ball_freeze <= 1'b1;
      o_serve       <= 1'b0;
      o_serve_dir   <= 1'b1;
      o_game_over   <= 1'b0;
      o_winner      <= 1'b0;
    end else begin
      state         <= state_nxt;
      pause_cnt     <= pause_cnt_nxt;
      blink_cnt     <= blink_cnt_nxt;
      blink_vis     <= blink_vis_nxt;
      score_p1      <= score_p1_nxt;
      score_p2      <= score_p2_nxt;
      o_ball_freeze <= (state_nxt != PLAY);
      o_serve       <= serve_nxt;
      o_serve_dir   <= serve_dir_nxt;
      o_game_over   <= (state_nxt == OVER);
      o_winner      <= winner_nxt;
      // Digits sample the pre-edge scores so a same-cycle point shows next frame.
      if (i_frame_start) begin
        o_digit_p1 <= digit_view(score_p1, hide_p1);
        o_digit_p2 <= digit_view(score_p2, hide_p2);
      end
    end
  end

endmodule

// File: tb/tb_score_controller.sv
// Bench for score_controller: directed scenarios plus random traffic, every
// output compared each cycle against a rule-level game model.
module tb_score_controller;

  localparam int WIN   = 3;
  localparam int PAUSE = 2;
  localparam int BLINK = 2;
  localparam int M_PLAY  = 0;
  localparam int M_PAUSE = 1;
  localparam int M_OVER  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       point_p1 = 1'b0;
  logic       point_p2 = 1'b0;
  logic       new_game = 1'b0;
  logic [6:0] digit_p1, digit_p2;
  logic       ball_freeze, serve, serve_dir, game_over, winner;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [0:9] = '{7'h77, 7'h24, 7'h5D, 7'h6D, 7'h2E,
                                7'h6B, 7'h7B, 7'h25, 7'h7F, 7'h6F};

  int         m_mode, m_s1, m_s2, m_frames, m_blink_seen;
  bit         m_show, m_dir, m_win, m_serve, m_freeze, m_over;
  logic [6:0] m_dig1, m_dig2;

  score_controller #(
    .WIN_SCORE   (WIN),
    .PAUSE_FRAMES(PAUSE),
    .BLINK_FRAMES(BLINK)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_frame_start(frame_start),
    .i_point_p1   (point_p1),
    .i_point_p2   (point_p2),
    .i_new_game   (new_game),
    .o_digit_p1   (digit_p1),
    .o_digit_p2   (digit_p2),
    .o_ball_freeze(ball_freeze),
    .o_serve      (serve),
    .o_serve_dir  (serve_dir),
    .o_game_over  (game_over),
    .o_winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Game rules applied once per clock edge, in terms of points, frames and modes.
  task automatic model(input logic fs, input logic p1, input logic p2,
                       input logic ng, input logic rs);
    int scorer;
    m_serve = 1'b0;
    if (rs) begin
      m_mode = M_PAUSE; m_frames = PAUSE; m_s1 = 0; m_s2 = 0;
      m_dig1 = 7'h77; m_dig2 = 7'h77; m_dir = 1'b1; m_win = 1'b0;
      m_show = 1'b1; m_blink_seen = 0;
    end else begin
      if (fs) begin
        m_dig1 = (m_mode == M_OVER && !m_show && m_win == 1'b0) ? 7'h00 : seg_tab[m_s1];
        m_dig2 = (m_mode == M_OVER && !m_show && m_win == 1'b1) ? 7'h00 : seg_tab[m_s2];
      end
      if (ng) begin
        m_s1 = 0; m_s2 = 0; m_dir = 1'b1; m_mode = M_PAUSE; m_frames = PAUSE;
      end else if (m_mode == M_PAUSE) begin
        if (fs) begin
          m_frames--;
          if (m_frames == 0) begin
            m_serve = 1'b1;
            m_mode  = M_PLAY;
          end
        end
      end else if (m_mode == M_PLAY) begin
        scorer = p1 ? 1 : (p2 ? 2 : 0);
        if (scorer != 0) begin
          if (scorer == 1) m_s1++; else m_s2++;
          m_dir = (scorer == 1);
          if ((scorer == 1 ? m_s1 : m_s2) == WIN) begin
            m_mode = M_OVER; m_win = (scorer == 2); m_show = 1'b1; m_blink_seen = 0;
          end else begin
            m_mode = M_PAUSE; m_frames = PAUSE;
          end
        end
      end else if (fs) begin
        m_blink_seen++;
        if (m_blink_seen == BLINK) begin
          m_show = !m_show;
          m_blink_seen = 0;
        end
      end
    end
    m_freeze = (m_mode != M_PLAY);
    m_over   = (m_mode == M_OVER);
  endtask

  task automatic step(input logic fs, input logic p1, input logic p2,
                      input logic ng, input logic rs);
    @(negedge clk);
    frame_start = fs; point_p1 = p1; point_p2 = p2; new_game = ng; rst = rs;
    @(posedge clk);
    model(fs, p1, p2, ng, rs);
    #1;
    chk("digit_p1", digit_p1, m_dig1);
    chk("digit_p2", digit_p2, m_dig2);
    chk("freeze", ball_freeze, m_freeze);
    chk("serve", serve, m_serve);
    chk("serve_dir", serve_dir, m_dir);
    chk("game_over", game_over, m_over);
    if (m_over) chk("winner", winner, m_win);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and first serve
    step(0, 0, 0, 0, 1);
    chk("rst_digit_p1", digit_p1, 7'h77);
    chk("rst_digit_p2", digit_p2, 7'h77);
    chk("rst_freeze", ball_freeze, 1'b1);
    chk("rst_serve_dir", serve_dir, 1'b1);
    idle(2);
    step(1, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0);
    chk("first_serve", serve, 1'b1);
    chk("first_serve_freeze", ball_freeze, 1'b0);
    chk("first_serve_dir", serve_dir, 1'b1);
    idle(1);
    chk("serve_one_cycle", serve, 1'b0);

    // Single point for player 1
    step(0, 1, 0, 0, 0);
    chk("pt_freeze", ball_freeze, 1'b1);
    chk("pt_dir", serve_dir, 1'b1);
    chk("pt_digit_held", digit_p1, 7'h77);
    idle(1);
    step(1, 0, 0, 0, 0);
    chk("pt_digit_p1", digit_p1, 7'h24);
    idle(1);
    step(1, 0, 0, 0, 0);
    chk("pt_serve", serve, 1'b1);
    idle(1);

    // Simultaneous points, then an ignored point during PAUSE
    step(0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("sim_digit_p1", digit_p1, 7'h5D);
    chk("sim_digit_p2", digit_p2, 7'h77);
    chk("sim_dir", serve_dir, 1'b1);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("ign_serve", serve, 1'b1);
    step(1, 0, 0, 0, 0);
    chk("ign_digit_p2", digit_p2, 7'h77);

    // Player 2 wins, winner's digit blinks
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0, 0);
      if (k < 2) begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("win_reserve", serve, 1'b1);
      end
    end
    idle(1);
    chk("win_over", game_over, 1'b1);
    chk("win_winner", winner, 1'b1);
    begin
      logic [6:0] blink_exp [0:4];
      blink_exp = '{7'h6D, 7'h6D, 7'h00, 7'h00, 7'h6D};
      for (int f = 0; f < 5; f++) begin
        step(1, 0, 0, 0, 0);
        chk("blink_p2", digit_p2, blink_exp[f]);
        chk("blink_p1", digit_p1, 7'h5D);
        idle(1);
      end
    end

    // Restart coinciding with a point, then reset mid-PAUSE
    step(0, 1, 0, 1, 0);
    chk("ng_over", game_over, 1'b0);
    step(1, 0, 0, 0, 0);
    chk("ng_digit_p1", digit_p1, 7'h77);
    chk("ng_digit_p2", digit_p2, 7'h77);
    step(1, 0, 0, 0, 0);
    chk("ng_serve", serve, 1'b1);
    chk("ng_dir", serve_dir, 1'b1);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("pre_rst_digit_p2", digit_p2, 7'h24);
    step(0, 0, 0, 0, 1);
    chk("mid_rst_digit_p2", digit_p2, 7'h77);
    chk("mid_rst_freeze", ball_freeze, 1'b1);
    chk("mid_rst_dir", serve_dir, 1'b1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(3) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0,
           $urandom_range(79) == 0, $urandom_range(499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_controller.md
# score_controller

Game-score sequencer for the Pong display path. Tracks both players' points and runs the serve/pause/game-over state machine. Drives the two 7-segment digit inputs of the score renderers, updating them only at frame boundaries so a digit never changes mid-frame. Sits between the ball/collision logic (point pulses) and the two digit renderers. Also gates ball motion via freeze and serve outputs.

## Interface
Parameters:
- WIN_SCORE, 9: points that end a game; legal range 1..9.
- PAUSE_FRAMES, 60: frames the ball is frozen after a point or at game start; legal range 1..255.
- BLINK_FRAMES, 30: frames per blink half-period of the winner's digit; legal range 1..255.

Ports:
- i_clk  input  1  pixel clock; one clock domain only.
- i_reset  input  1  synchronous, active-high reset.
- i_frame_start  input  1  one-cycle pulse, once per frame, at the start of vertical blank.
- i_point_p1  input  1  one-cycle pulse; player 1 scored.
- i_point_p2  input  1  one-cycle pulse; player 2 scored.
- i_new_game  input  1  one-cycle pulse; restart the match.
- o_digit_p1  output  7  segment pattern for the player 1 score.
- o_digit_p2  output  7  segment pattern for the player 2 score.
- o_ball_freeze  output  1  1 = ball held at centre.
- o_serve  output  1  one-cycle pulse; release the ball.
- o_serve_dir  output  1  0 = toward player 1, 1 = toward player 2.
- o_game_over  output  1  high while in OVER.
- o_winner  output  1  0 = player 1, 1 = player 2; valid while o_game_over = 1.

## Operation
- Segment bit map: bit0 top, bit1 upper-left, bit2 upper-right, bit3 middle, bit4 lower-left, bit5 lower-right, bit6 bottom.
- Encoding for digits 0..9: 77, 24, 5D, 6D, 2E, 6B, 7B, 25, 7F, 6F (hex). Score values are 4 bits and never exceed 9.
- States: PLAY, PAUSE, OVER.
- PAUSE:
  - o_ball_freeze = 1.
  - A frame counter loads PAUSE_FRAMES on entry and decrements on each i_frame_start.
  - The i_frame_start that takes the counter from 1 to 0 causes, on the same edge, o_serve = 1 for one cycle and a move to PLAY.
- PLAY:
  - o_ball_freeze = 0.
  - i_point_pX increments score_pX.
  - o_serve_dir is set toward the player who conceded (point_p1 → 1, point_p2 → 0).
  - If the new score equals WIN_SCORE: go to OVER with o_winner = X. Otherwise go to PAUSE.
- OVER:
  - o_ball_freeze = 1 and o_game_over = 1.
  - A blink counter toggles a blink phase every BLINK_FRAMES frame_starts. The phase is visible on entry.
  - While the phase is hidden, the winner's digit shows 00. The loser's digit always shows its score.
- i_new_game in any state:
  - Scores go to 0, o_serve_dir = 1, o_game_over = 0.
  - Enter PAUSE with the counter reloaded.
- Points are ignored outside PLAY.
- Both points in the same cycle: player 1 takes priority and the player 2 pulse is dropped.
- i_new_game coinciding with a point: i_new_game wins and the point is dropped.
- Digit registers load the encoded scores (and blink mask) only in the cycle where i_frame_start = 1. They hold their value otherwise.

## Timing
- Reset values:
  - State PAUSE, pause counter = PAUSE_FRAMES, scores 0.
  - o_digit_p1 = o_digit_p2 = 77.
  - o_ball_freeze = 1, o_serve = 0, o_serve_dir = 1, o_game_over = 0, o_winner = 0.
  - Blink phase visible.
- Reset mid-operation overrides every other input on that edge.
- All outputs are registered.
- Point latency:
  - Score and state update on the edge that samples the pulse.
  - o_ball_freeze rises the cycle after.
  - o_game_over and o_winner are valid the cycle after the winning point.
  - o_digit updates on the first i_frame_start strictly after the point. A frame_start in the same cycle as the point latches the old score.
- o_serve is never asserted in two consecutive cycles. It is never asserted in the same cycle as o_ball_freeze = 0 from PLAY.
- When i_frame_start and the point that starts PAUSE fall in the same cycle, that frame_start does not decrement the counter.

## Test plan
Bench parameters: WIN_SCORE = 3, PAUSE_FRAMES = 2, BLINK_FRAMES = 2.

- **Reset and first serve.** Reset, then 2 frame_starts → digits 77/77. o_serve pulses on the 2nd frame_start edge with o_serve_dir = 1. o_ball_freeze falls the same cycle.
- **Single point.** In PLAY, pulse i_point_p1 → freeze = 1 next cycle, serve_dir = 1. o_digit_p1 = 24 only after the next frame_start. The serve follows 2 frames later.
- **Simultaneous points.** i_point_p1 and i_point_p2 in the same cycle → p1 score +1, p2 unchanged, serve_dir = 1.
- **Ignored point.** A point pulse during PAUSE → scores unchanged and the counter is unaffected.
- **Win and blink.** p2 scores 3 times → o_game_over = 1, o_winner = 1. o_digit_p2 sequence over frames is 6D, 6D, 00, 00, 6D. No o_serve is issued.
- **Restart.** i_new_game during OVER, coinciding with i_point_p1 → scores 0, point dropped. Digits read 77/77 at the next frame_start, then a serve with dir = 1 after 2 frames. A reset asserted mid-PAUSE restores all reset values.
